// File: rtl/ppi_port_c_unit.sv
// ppi_port_c_unit: Port C latch, control register and CPU bus-cycle FSM.
// Writes are committed on the trailing edge of wr_n; reads return Port C
// with per-nibble selection between the pins and the output latch.
module ppi_port_c_unit #(
    parameter logic [7:0] RESET_CTRL = 8'h9B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] port_c_in,
    output logic [7:0] port_c_out,
    output logic       port_c_oe_upper,
    output logic       port_c_oe_lower,
    output logic [7:0] ctrl_word,
    output logic       wr_done
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WR_HOLD   = 2'd1;
    localparam logic [1:0] RD_ACTIVE = 2'd2;

    localparam logic [1:0] ADDR_PC   = 2'b10;
    localparam logic [1:0] ADDR_CTRL = 2'b11;

    logic [1:0] state;
    logic [1:0] cap_addr;
    logic [7:0] cap_data;

    logic wr_req;
    logic rd_req;
    logic commit;
    logic [7:0] rd_mux;

    // A write strobe wins over a simultaneous read strobe.
    assign wr_req = !cs_n && !wr_n;
    assign rd_req = !cs_n && !rd_n && wr_n;
    // Trailing edge of the write strobe with chip select still held.
    assign commit = (state == WR_HOLD) && !cs_n && wr_n;

    // Nibble-wise read source: input nibbles return pins, output nibbles the latch.
    assign rd_mux = {ctrl_word[3] ? port_c_in[7:4] : port_c_out[7:4],
                     ctrl_word[0] ? port_c_in[3:0] : port_c_out[3:0]};

    assign port_c_oe_upper = ~ctrl_word[3];
    assign port_c_oe_lower = ~ctrl_word[0];

    // Bus-cycle FSM; captures write address/data on every strobe-low sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cap_addr <= 2'b00;
            cap_data <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        state    <= WR_HOLD;
                        cap_addr <= addr;
                        cap_data <= data_in;
                    end else if (rd_req) begin
                        state <= RD_ACTIVE;
                    end
                end
                WR_HOLD: begin
                    if (cs_n) begin
                        state <= IDLE;
                    end else if (wr_n) begin
                        state <= IDLE;
                    end else begin
                        cap_addr <= addr;
                        cap_data <= data_in;
                    end
                end
                RD_ACTIVE: begin
                    if (wr_req) begin
                        state    <= WR_HOLD;
                        cap_addr <= addr;
                        cap_data <= data_in;
                    end else if (rd_n || cs_n) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Commit of the captured write into the control register / Port C latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_word  <= RESET_CTRL;
            port_c_out <= 8'h00;
            wr_done    <= 1'b0;
        end else begin
            wr_done <= commit && cap_addr[1];
            if (commit) begin
                if (cap_addr == ADDR_PC) begin
                    port_c_out <= cap_data;
                end else if (cap_addr == ADDR_CTRL) begin
                    if (cap_data[7]) begin
                        // Mode set also clears the output latch.
                        ctrl_word  <= cap_data;
                        port_c_out <= 8'h00;
                    end else begin
                        port_c_out[cap_data[3:1]] <= cap_data[0];
                    end
                end
            end
        end
    end

    // Registered read path; only Port C reads drive the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= 8'h00;
            data_oe  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!wr_req && rd_req) begin
                        data_oe  <= (addr == ADDR_PC);
                        data_out <= rd_mux;
                    end else begin
                        data_oe <= 1'b0;
                    end
                end
                RD_ACTIVE: begin
                    if (wr_req || rd_n || cs_n) begin
                        data_oe <= 1'b0;
                    end else begin
                        data_oe  <= (addr == ADDR_PC);
                        data_out <= rd_mux;
                    end
                end
                default: data_oe <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ppi_port_c_unit.sv
// Directed bench for ppi_port_c_unit: reset, mode set, Port C writes, BSR,
// reads, abort, read/write priority, reset mid-write and back-to-back writes.
module tb_ppi_port_c_unit;

    logic       clk;
    logic       rst;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] port_c_in;
    logic [7:0] port_c_out;
    logic       port_c_oe_upper;
    logic       port_c_oe_lower;
    logic [7:0] ctrl_word;
    logic       wr_done;

    int total = 0;
    int bad   = 0;

    ppi_port_c_unit #(.RESET_CTRL(8'h9B)) dut (
        .clk             (clk),
        .rst             (rst),
        .cs_n            (cs_n),
        .wr_n            (wr_n),
        .rd_n            (rd_n),
        .addr            (addr),
        .data_in         (data_in),
        .data_out        (data_out),
        .data_oe         (data_oe),
        .port_c_in       (port_c_in),
        .port_c_out      (port_c_out),
        .port_c_oe_upper (port_c_oe_upper),
        .port_c_oe_lower (port_c_oe_lower),
        .ctrl_word       (ctrl_word),
        .wr_done         (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    endtask

    // One-sample write strobe; leaves the bench just after the commit edge.
    task automatic wr_start(input logic [1:0] a, input logic [7:0] d);
        cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; addr = a; data_in = d;
        cyc();
        wr_n = 1'b1;
        cyc();
    endtask

    // Full write ending with an idle cycle; checks wr_done is one cycle wide.
    task automatic wr_full(input string tag, input logic [1:0] a, input logic [7:0] d,
                           input logic exp_done);
        wr_start(a, d);
        chk({tag, "_done"}, {7'd0, wr_done}, {7'd0, exp_done});
        bus_idle();
        cyc();
        chk({tag, "_done_end"}, {7'd0, wr_done}, 8'h00);
    endtask

    // Read one cycle, check bus output, release.
    task automatic rd_chk(input string tag, input logic [1:0] a,
                          input logic exp_oe, input logic [7:0] exp_data);
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; addr = a;
        cyc();
        chk({tag, "_oe"}, {7'd0, data_oe}, {7'd0, exp_oe});
        if (exp_oe) chk({tag, "_data"}, data_out, exp_data);
        bus_idle();
        cyc();
        chk({tag, "_oe_off"}, {7'd0, data_oe}, 8'h00);
    endtask

    initial begin
        rst = 1'b1; bus_idle(); addr = 2'b00; data_in = 8'h00; port_c_in = 8'h00;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_ctrl", ctrl_word, 8'h9B);
        chk("rst_pco", port_c_out, 8'h00);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_oe", {6'd0, data_oe, wr_done}, 8'h00);
        chk("rst_pc_oe", {6'd0, port_c_oe_upper, port_c_oe_lower}, 8'h00);

        // All-input mode: read returns the pins.
        port_c_in = 8'hA5;
        rd_chk("rd_in", 2'b10, 1'b1, 8'hA5);

        // Mode set to all outputs, then Port C write.
        wr_full("mode80", 2'b11, 8'h80, 1'b1);
        chk("mode80_ctrl", ctrl_word, 8'h80);
        chk("mode80_pc_oe", {6'd0, port_c_oe_upper, port_c_oe_lower}, 8'h03);
        wr_full("pc3c", 2'b10, 8'h3C, 1'b1);
        chk("pc3c_pco", port_c_out, 8'h3C);
        rd_chk("rd_3c", 2'b10, 1'b1, 8'h3C);

        // BSR set bit 7, then clear bit 2.
        wr_full("bsr0f", 2'b11, 8'h0F, 1'b1);
        chk("bsr0f_pco", port_c_out, 8'hBC);
        wr_full("bsr04", 2'b11, 8'h04, 1'b1);
        chk("bsr04_pco", port_c_out, 8'hB8);
        chk("bsr_ctrl", ctrl_word, 8'h80);

        // Mode 88: upper input, lower output; latch cleared.
        port_c_in = 8'h5A;
        wr_full("mode88", 2'b11, 8'h88, 1'b1);
        chk("mode88_pco", port_c_out, 8'h00);
        chk("mode88_pc_oe", {6'd0, port_c_oe_upper, port_c_oe_lower}, 8'h01);
        rd_chk("rd_50", 2'b10, 1'b1, 8'h50);

        // Control register is write-only; port A write touches nothing here.
        rd_chk("rd_ctrl", 2'b11, 1'b0, 8'h00);
        wr_full("wr_a", 2'b00, 8'hFF, 1'b0);
        chk("wr_a_pco", port_c_out, 8'h00);
        chk("wr_a_ctrl", ctrl_word, 8'h88);

        // Abort: cs_n rises with wr_n still low.
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'b10; data_in = 8'hFF;
        cyc();
        cs_n = 1'b1;
        cyc();
        wr_n = 1'b1;
        chk("abort_done", {7'd0, wr_done}, 8'h00);
        cyc();
        chk("abort_done2", {7'd0, wr_done}, 8'h00);
        chk("abort_pco", port_c_out, 8'h00);

        // rd_n and wr_n low together: write wins, bus never driven.
        cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; addr = 2'b10; data_in = 8'h77;
        cyc();
        chk("both_oe", {7'd0, data_oe}, 8'h00);
        wr_n = 1'b1; rd_n = 1'b1;
        cyc();
        chk("both_pco", port_c_out, 8'h77);
        chk("both_done", {7'd0, wr_done}, 8'h01);
        chk("both_oe2", {7'd0, data_oe}, 8'h00);
        bus_idle();
        cyc();

        // Reset arriving in WR_HOLD drops the pending mode set.
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'b11; data_in = 8'hC0;
        cyc();
        wr_n = 1'b1; rst = 1'b1;
        cyc();
        rst = 1'b0; bus_idle();
        chk("rstwr_ctrl", ctrl_word, 8'h9B);
        chk("rstwr_pco", port_c_out, 8'h00);
        cyc();
        chk("rstwr_ctrl2", ctrl_word, 8'h9B);
        chk("rstwr_done", {7'd0, wr_done}, 8'h00);

        // Back-to-back writes to Port C.
        wr_full("mode80b", 2'b11, 8'h80, 1'b1);
        wr_start(2'b10, 8'h11);
        chk("b2b1_pco", port_c_out, 8'h11);
        chk("b2b1_done", {7'd0, wr_done}, 8'h01);
        wr_n = 1'b0; data_in = 8'h22;
        cyc();
        chk("b2b_gap_done", {7'd0, wr_done}, 8'h00);
        chk("b2b_gap_pco", port_c_out, 8'h11);
        wr_n = 1'b1;
        cyc();
        chk("b2b2_pco", port_c_out, 8'h22);
        chk("b2b2_done", {7'd0, wr_done}, 8'h01);
        bus_idle();
        cyc();
        chk("b2b_end_done", {7'd0, wr_done}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
